mul_pair_engine: RTL
====================

# mul_pair_engine

Hardware responder for the program-3 start/done protocol. It sits beside the data memory: it reads 16 pairs of 16-bit two's-complement operands from the memory, forms the exact 32-bit signed products, and writes them back big-endian to the result region. It then raises `done` for the initiator, which holds `reset` high to idle the engine and releases it to start a run.

## Interface
Parameters:
- `NUM_PAIRS`, 16: operand pairs per run, range 1..16.
- `SRC_BASE`, 0: byte address of operand 0.
- `DST_BASE`, 64: byte address of product 0.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-high. High means idle and clear; release starts a run.
- `mem_addr`, out, 8: byte address to data memory.
- `mem_rd_data`, in, 8: memory read data, combinational from `mem_addr` in the same cycle.
- `mem_wr_en`, out, 1: write strobe, sampled by the memory on the rising edge.
- `mem_wr_data`, out, 8: write byte.
- `busy`, out, 1: run in progress.
- `done`, out, 1: all products written; held until `reset`.

## Operation
- **Operand layout:** operand i = {mem[SRC_BASE+2i], mem[SRC_BASE+2i+1]}, MSB byte first.
  - Pair k: A = operand 2k, B = operand 2k+1.
  - P = B*A, signed 16x16 to 32, exact over the full range; -32768*-32768 = 0x4000_0000.
- **Result layout:** P_k is written to DST_BASE+4k .. +4k+3, MSB byte first.
- **States:**
  - RESET: held while `reset` is high.
  - LOAD: 4 cycles. Reads bytes 4k..4k+3 relative to SRC_BASE into A_hi, A_lo, B_hi, B_lo.
  - MUL: 16 cycles, one radix-2 iteration per cycle on a 33-bit partial product; Booth or sign-magnitude, but exactly 16 cycles.
  - STORE: 4 cycles. Writes P[31:24], P[23:16], P[15:8], P[7:0] to successive addresses with `mem_wr_en` = 1.
  - After STORE: if k < NUM_PAIRS-1, increment k and go to LOAD; otherwise go to DONE.
  - DONE: terminal; `done` = 1, `busy` = 0, no memory activity.
- **Memory discipline:**
  - `mem_wr_en` is high only in STORE, and only when `mem_addr` is in DST_BASE..DST_BASE+4*NUM_PAIRS-1.
  - The engine never writes the source region.
- **Address arithmetic:** 8-bit. Wraps mod 256 and is not checked; the parameters must keep both regions within 0..255.

## Timing
- **Reset values** (asynchronous, while `reset` is high):
  - state = LOAD-pending, k = 0
  - `mem_addr` = SRC_BASE, `mem_wr_en` = 0, `mem_wr_data` = 0
  - `busy` = 0, `done` = 0
- **Run start:** the first rising edge after `reset` falls captures byte SRC_BASE. `busy` is 1 from the release until DONE.
- **Per-pair latency:** 24 cycles (4 LOAD + 16 MUL + 4 STORE).
- **Total latency:** `done` rises on edge NUM_PAIRS*24 after release; 384 cycles for the default.
- **Done hold:** `done` stays 1 until `reset` rises, then clears asynchronously.
- **Reset mid-run:**
  - Immediate abort; bytes already written stay in memory.
  - The next release restarts from pair 0 and overwrites all results.
- **Reset in DONE:** clears `done`; on release, a full new run starts.
- **Output registration:** `mem_addr`, `mem_wr_en` and `mem_wr_data` are registered; no combinational path from `mem_rd_data` to any output.

## Configuration
- `MUL_EARLY_ZERO_EN` defined:
  - After LOAD, if A == 0 or B == 0, skip MUL and go directly to STORE with P = 0.
  - That pair takes 8 cycles instead of 24.
- Undefined: every pair takes 24 cycles regardless of operand values.
- Results are identical in both builds; only cycle counts differ.

## Test plan
- **All-zero operands:**
  - Release `reset` with mem[0:63] = 0 and mem[64:127] = 0xFF.
  - Required: mem[64:127] = 0 and `done` on edge 384. With `MUL_EARLY_ZERO_EN`: edge 128.
- **Extreme values:**
  - Pair 0: A = 0x8000, B = 0x8000. Required P = 0x40000000.
  - Pair 1: A = 0x7FFF, B = 0xFFFF (-1). Required P = 0xFFFF8001.
  - Pair 2: A = 0x8000, B = 0x7FFF. Required P = 0xC0008000.
- **Random sweep:** 10 runs of random operands, each with a reset pulse between runs. All 16 products must match the 32-bit signed reference, and mem[0:63] must be unchanged.
- **Reset mid-run:**
  - Assert `reset` at cycle 100: `done`, `busy` and `mem_wr_en` must read 0 within the same cycle.
  - Change the operands, then release: the final mem[64:127] must reflect only the new operands.
- **Done hold and boundary:**
  - Hold `reset` low for 200 cycles after `done`: `done` stays 1 and `mem_wr_en` stays 0.
  - mem[128:255] is never written, including with preset values such as mem[128] = 0x80.

Source files
------------

// File: rtl/mul_pair_engine.sv
// Start/done responder: reads NUM_PAIRS signed 16-bit operand pairs, multiplies each with a
// 16-cycle radix-2 Booth loop and writes the 32-bit products back MSB first.
// Optional MUL_EARLY_ZERO_EN: a pair with a zero operand skips the multiply loop.
module mul_pair_engine #(
  parameter int unsigned NUM_PAIRS = 16,
  parameter int unsigned SRC_BASE  = 0,
  parameter int unsigned DST_BASE  = 64
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StLoad, StMul, StStore, StDone} state_e;

  localparam logic [7:0] SrcBase  = 8'(SRC_BASE);
  localparam logic [7:0] DstBase  = 8'(DST_BASE);
  localparam logic [3:0] LastPair = 4'(NUM_PAIRS - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  pair_q, pair_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic [16:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic        qm1_q, qm1_d;
  logic [7:0]  addr_q, addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [15:0] b_full;
  logic [16:0] a_ext, acc;
  logic [16:0] hi_step;
  logic [15:0] lo_step;
  logic [31:0] prod_step, product;
  logic [3:0]  pair_inc;
  logic [7:0]  dst_addr, src_next;
  logic        skip_mul, last_pair;

  // B low byte is still on the bus during the last LOAD cycle.
  assign b_full    = {b_hi_q, mem_rd_data};
  assign a_ext     = {a_q[15], a_q};
  assign product   = {hi_q[15:0], lo_q};
  assign pair_inc  = pair_q + 4'd1;
  assign dst_addr  = DstBase + {2'b00, pair_q, 2'b00};
  assign src_next  = SrcBase + {2'b00, pair_inc, 2'b00};
  assign last_pair = (pair_q == LastPair);

`ifdef MUL_EARLY_ZERO_EN
  assign skip_mul = (a_q == 16'd0) || (b_full == 16'd0);
`else
  assign skip_mul = 1'b0;
`endif

  // One Booth iteration on the 17-bit high half, then arithmetic shift of {hi, lo, q-1}.
  always_comb begin
    unique case ({lo_q[0], qm1_q})
      2'b01:   acc = hi_q + a_ext;
      2'b10:   acc = hi_q - a_ext;
      default: acc = hi_q;
    endcase
    hi_step   = {acc[16], acc[16:1]};
    lo_step   = {acc[0], lo_q[15:1]};
    prod_step = {hi_step[15:0], lo_step};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StLoad;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (cnt_q == 4'd3)  state_d = skip_mul ? StStore : StMul;
      StMul:   if (cnt_q == 4'd15) state_d = StStore;
      StStore: if (cnt_q == 4'd3)  state_d = last_pair ? StDone : StLoad;
      StDone:  state_d = StDone;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    pair_d    = pair_q;
    a_d       = a_q;
    b_hi_d    = b_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    qm1_d     = qm1_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;

    if (state_q == StDone)       cnt_d = cnt_q;
    else if (state_d != state_q) cnt_d = 4'd0;
    else                         cnt_d = cnt_q + 4'd1;

    unique case (state_q)
      StLoad: begin
        unique case (cnt_q[1:0])
          2'd0:    a_d[15:8] = mem_rd_data;
          2'd1:    a_d[7:0]  = mem_rd_data;
          2'd2:    b_hi_d    = mem_rd_data;
          default: ;
        endcase
        if (cnt_q != 4'd3) begin
          addr_d = addr_q + 8'd1;
        end else begin
          hi_d  = '0;
          lo_d  = skip_mul ? 16'd0 : b_full;
          qm1_d = 1'b0;
          if (skip_mul) begin
            addr_d    = dst_addr;
            wr_en_d   = 1'b1;
            wr_data_d = 8'h00;
          end
        end
      end
      StMul: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        qm1_d = lo_q[0];
        // Final iteration: the product MSB byte is launched together with the first store.
        if (cnt_q == 4'd15) begin
          addr_d    = dst_addr;
          wr_en_d   = 1'b1;
          wr_data_d = prod_step[31:24];
        end
      end
      StStore: begin
        if (cnt_q != 4'd3) begin
          addr_d  = addr_q + 8'd1;
          wr_en_d = 1'b1;
          unique case (cnt_q[1:0])
            2'd0:    wr_data_d = product[23:16];
            2'd1:    wr_data_d = product[15:8];
            default: wr_data_d = product[7:0];
          endcase
        end else begin
          wr_data_d = 8'h00;
          if (!last_pair) begin
            pair_d = pair_inc;
            addr_d = src_next;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pair_q    <= '0;
      a_q       <= '0;
      b_hi_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      qm1_q     <= 1'b0;
      addr_q    <= SrcBase;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pair_q    <= pair_d;
      a_q       <= a_d;
      b_hi_q    <= b_hi_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      qm1_q     <= qm1_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    mem_addr    = addr_q;
    mem_wr_en   = wr_en_q;
    mem_wr_data = wr_data_q;
    done        = (state_q == StDone);
    busy        = (state_q != StDone) && !reset;
  end

endmodule
